vga_timing_gen: RTL

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen_pkg.sv | 59 +++++
 rtl/vga_timing_gen_wrap_counter.sv | 36 +++
 rtl/vga_timing_gen.sv | 118 +++++++++++
 3 files changed

// File: rtl/vga_timing_gen_pkg.sv
// Shared VGA 640x480@60 timing constants, coordinate type and output bundle.
// Imported by vga_wrap_counter and vga_timing_gen.
package vga_pkg;

  // 10 bits is enough for both the 0..799 column and the 0..524 line range.
  typedef logic [9:0] coord_t;

  // Horizontal line: active, front porch, sync pulse, back porch.
  localparam int H_ACTIVE_STD = 640;
  localparam int H_FP         = 16;
  localparam int H_SYNC       = 96;
  localparam int H_BP         = 48;
  localparam int H_TOTAL      = H_ACTIVE_STD + H_FP + H_SYNC + H_BP;

  // Vertical frame: active, front porch, sync pulse, back porch.
  localparam int V_ACTIVE_STD = 480;
  localparam int V_FP         = 10;
  localparam int V_SYNC       = 2;
  localparam int V_BP         = 33;
  localparam int V_TOTAL      = V_ACTIVE_STD + V_FP + V_SYNC + V_BP;

  // Sync windows as [start, end) in counter units.
  localparam coord_t H_SYNC_START = coord_t'(H_ACTIVE_STD + H_FP);
  localparam coord_t H_SYNC_END   = coord_t'(H_ACTIVE_STD + H_FP + H_SYNC);
  localparam coord_t V_SYNC_START = coord_t'(V_ACTIVE_STD + V_FP);
  localparam coord_t V_SYNC_END   = coord_t'(V_ACTIVE_STD + V_FP + V_SYNC);

  // Phase of the optional clk/2 pixel-tick divider.
  typedef enum logic {
    PH_IDLE = 1'b0,
    PH_TICK = 1'b1
  } div_phase_t;

  // Everything that is registered together on a pixel tick.
  typedef struct packed {
    coord_t x;
    coord_t y;
    logic   hsync;
    logic   vsync;
    logic   blankN;
    logic   frameStart;
  } vga_out_t;

  // Idle levels: syncs deasserted (high), blanked, no frame marker.
  localparam vga_out_t VGA_OUT_RESET = '{
    x:          '0,
    y:          '0,
    hsync:      1'b1,
    vsync:      1'b1,
    blankN:     1'b0,
    frameStart: 1'b0
  };

  // True when value lies in the half-open window [lo, hiExcl).
  function automatic logic inWindow(input coord_t value, input coord_t lo, input coord_t hiExcl);
    return (value >= lo) && (value < hiExcl);
  endfunction

endpackage

// File: rtl/vga_timing_gen_wrap_counter.sv
// vga_wrap_counter: enabled up-counter that folds back to zero after TERMINAL.
// o_wrap is high in the enabled cycle in which the counter sits at TERMINAL,
// so it can directly enable a cascaded counter.
module vga_wrap_counter
  import vga_pkg::*;
#(
  parameter int TERMINAL = 799
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   i_en,
  output coord_t o_count,
  output logic   o_wrap
);

  coord_t r_count;
  logic   w_atTerminal;

  assign w_atTerminal = (r_count == coord_t'(TERMINAL));
  assign o_wrap       = i_en & w_atTerminal;
  assign o_count      = r_count;

  // Advance on enable; after the terminal value return to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_en) begin
      if (w_atTerminal) begin
        r_count <= '0;
      end else begin
        r_count <= r_count + coord_t'(1);
      end
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 VGA raster timing (800x525 ticks per frame).
// Optional macro VGA_CLKDIV_EN: derive the 25 MHz pixel tick from a 50 MHz clk
// by a divide-by-2 toggle; when undefined, clk itself is the pixel clock.
// All decoded outputs are registered on the pixel tick, one tick behind the
// counters they are decoded from.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic   clk,
  input  logic   rst,
  output logic   pix_en,
  output logic   vga_clk,
  output coord_t x,
  output coord_t y,
  output logic   hsync,
  output logic   vsync,
  output logic   blank_n,
  output logic   sync_n,
  output logic   frame_start
);

  localparam coord_t H_ACT_C = coord_t'(H_ACTIVE);
  localparam coord_t V_ACT_C = coord_t'(V_ACTIVE);

  logic     w_pixEn;
  coord_t   w_hcnt;
  coord_t   w_vcnt;
  logic     w_hWrap;
  logic     w_vWrap;
  logic     r_atOrigin;
  vga_out_t w_next;
  vga_out_t r_out;

`ifdef VGA_CLKDIV_EN
  div_phase_t r_phase;

  // Toggle the divider phase every clk so every second clk is a pixel tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase <= PH_IDLE;
    end else begin
      r_phase <= (r_phase == PH_IDLE) ? PH_TICK : PH_IDLE;
    end
  end

  assign w_pixEn = (r_phase == PH_TICK);
  assign vga_clk = w_pixEn;
`else
  assign w_pixEn = 1'b1;
  assign vga_clk = clk;
`endif

  assign pix_en = w_pixEn;

  vga_wrap_counter #(
    .TERMINAL (H_TOTAL - 1)
  ) u_hCounter (
    .clk     (clk),
    .rst     (rst),
    .i_en    (w_pixEn),
    .o_count (w_hcnt),
    .o_wrap  (w_hWrap)
  );

  vga_wrap_counter #(
    .TERMINAL (V_TOTAL - 1)
  ) u_vCounter (
    .clk     (clk),
    .rst     (rst),
    .i_en    (w_hWrap),
    .o_count (w_vcnt),
    .o_wrap  (w_vWrap)
  );

  // Mark that both counters rest at (0,0): true out of reset and right after
  // the last pixel of the frame, consumed by the next pixel tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_atOrigin <= 1'b1;
    end else if (w_vWrap) begin
      r_atOrigin <= 1'b1;
    end else if (w_pixEn) begin
      r_atOrigin <= 1'b0;
    end
  end

  // Decode the raster outputs for the current counter pair.
  always_comb begin
    w_next            = VGA_OUT_RESET;
    w_next.x          = w_hcnt;
    w_next.y          = w_vcnt;
    w_next.hsync      = ~inWindow(w_hcnt, H_SYNC_START, H_SYNC_END);
    w_next.vsync      = ~inWindow(w_vcnt, V_SYNC_START, V_SYNC_END);
    w_next.blankN     = (w_hcnt < H_ACT_C) && (w_vcnt < V_ACT_C);
    w_next.frameStart = r_atOrigin;
  end

  // Capture the decoded bundle on each pixel tick and hold it in between.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out <= VGA_OUT_RESET;
    end else if (w_pixEn) begin
      r_out <= w_next;
    end
  end

  assign x           = r_out.x;
  assign y           = r_out.y;
  assign hsync       = r_out.hsync;
  assign vsync       = r_out.vsync;
  assign blank_n     = r_out.blankN;
  assign frame_start = r_out.frameStart;
  assign sync_n      = 1'b0;

endmodule
